// File: rtl/simon_says_multi.sv
// simon_says_multi: parametrised Simon-says core with an LFSR-generated sequence, tick divider, input timeout and win state.
// Optional build macro SIMON_SPEEDUP_EN shortens SHOW_ON playback by one tick every 4 rounds.
module simon_says_multi #(
  parameter int          NUM_BTNS      = 4,
  parameter int          MAX_LEN       = 16,
  parameter int          CLKDIV_LIM    = 15,
  parameter int          ON_TICKS      = 2,
  parameter int          TIMEOUT_TICKS = 20,
  parameter logic [7:0]  SEED          = 8'hA5,
  localparam int         EW            = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1,
  localparam int         LW            = $clog2(MAX_LEN + 1)
) (
  input  logic                hz100,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BTNS-1:0] pb,
  output logic [NUM_BTNS-1:0] led,
  output logic [LW-1:0]       level,
  output logic [2:0]          state,
  output logic                red,
  output logic                green,
  output logic                blue
);

  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DW   = (CLKDIV_LIM > 0) ? $clog2(CLKDIV_LIM + 1) : 1;
  localparam int TMAX = (ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int EW1  = EW + 1;

  localparam logic [DW-1:0]       DIV_LAST = DW'(CLKDIV_LIM);
  localparam logic [DW-1:0]       DIV_ONE  = DW'(1);
  localparam logic [TW-1:0]       TICK_ONE = TW'(1);
  localparam logic [TW-1:0]       ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]       TO_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [LW-1:0]       LEN_MAX  = LW'(MAX_LEN);
  localparam logic [LW-1:0]       LEN_ONE  = LW'(1);
  localparam logic [IW-1:0]       IDX_ONE  = IW'(1);
  localparam logic [EW:0]         NB       = EW1'(NUM_BTNS);
  localparam logic [NUM_BTNS-1:0] LED_ONE  = NUM_BTNS'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_APPEND   = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t              state_r, state_next_s;
  logic [7:0]          lfsr_r;
  logic                start_q_r;
  logic [NUM_BTNS-1:0] pb_q_r;
  logic [LW-1:0]       len_r;
  logic [IW-1:0]       idx_r;
  logic [EW-1:0]       seq_r [MAX_LEN];
  logic [DW-1:0]       divcnt_r;
  logic [TW-1:0]       tickcnt_r;

  logic                tick_s, start_rise_s, press_any_s, press_one_s, idx_last_s;
  logic [NUM_BTNS-1:0] press_s, expect_led_s;
  logic [EW-1:0]       elem_raw_s, elem_s;
  logic [TW-1:0]       on_last_s;
  logic                len_clr_s, append_s, idx_clr_s, idx_inc_s, restart_s;

  function automatic logic [NUM_BTNS-1:0] onehot(input logic [EW-1:0] e);
    onehot = LED_ONE << e;
  endfunction

  function automatic logic single_bit(input logic [NUM_BTNS-1:0] v);
    single_bit = (v != '0) && ((v & (v - LED_ONE)) == '0);
  endfunction

  assign tick_s       = (divcnt_r == DIV_LAST);
  assign start_rise_s = start & ~start_q_r;
  assign press_s      = pb & ~pb_q_r;
  assign press_any_s  = |press_s;
  assign press_one_s  = single_bit(press_s);
  assign elem_raw_s   = lfsr_r[EW-1:0];
  assign expect_led_s = onehot(seq_r[idx_r]);
  assign idx_last_s   = ((LW'(idx_r) + LEN_ONE) == len_r);

  // Fold out-of-range LFSR samples back into the button range
  always_comb begin
    if ({1'b0, elem_raw_s} >= NB) elem_s = elem_raw_s - NB[EW-1:0];
    else                          elem_s = elem_raw_s;
  end

`ifdef SIMON_SPEEDUP_EN
  // Last SHOW_ON tick index shrinks by one every 4 rounds, never below a single tick
  always_comb begin
    if (int'(len_r >> 2'd2) < ON_TICKS - 1) on_last_s = TW'(ON_TICKS - 1 - int'(len_r >> 2'd2));
    else                                    on_last_s = '0;
  end
`else
  assign on_last_s = ON_LAST;
`endif

  // State register
  always_ff @(posedge hz100) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state and datapath control decode
  always_comb begin
    state_next_s = state_r;
    len_clr_s    = 1'b0;
    append_s     = 1'b0;
    idx_clr_s    = 1'b0;
    idx_inc_s    = 1'b0;
    restart_s    = 1'b0;
    case (state_r)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_rise_s) begin
          state_next_s = S_APPEND;
          len_clr_s    = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      S_APPEND: begin
        state_next_s = S_SHOW_ON;
        append_s     = 1'b1;
        idx_clr_s    = 1'b1;
      end
      S_SHOW_ON: begin
        if (tick_s && (tickcnt_r == on_last_s)) state_next_s = S_SHOW_OFF;
        else                                    state_next_s = S_SHOW_ON;
      end
      S_SHOW_OFF: begin
        if (tick_s && idx_last_s) begin
          state_next_s = S_INPUT;
          idx_clr_s    = 1'b1;
        end else if (tick_s) begin
          state_next_s = S_SHOW_ON;
          idx_inc_s    = 1'b1;
        end else begin
          state_next_s = S_SHOW_OFF;
        end
      end
      S_INPUT: begin
        // A press beats a timeout tick landing in the same cycle
        if (press_any_s) begin
          if (press_one_s && (press_s == expect_led_s)) begin
            if (!idx_last_s) begin
              state_next_s = S_INPUT;
              idx_inc_s    = 1'b1;
              restart_s    = 1'b1;
            end else if (len_r == LEN_MAX) begin
              state_next_s = S_WIN;
            end else begin
              state_next_s = S_APPEND;
            end
          end else begin
            state_next_s = S_LOSE;
          end
        end else if (tick_s && (tickcnt_r == TO_LAST)) begin
          state_next_s = S_LOSE;
        end else begin
          state_next_s = S_INPUT;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // LFSR, edge-detect history, sequence storage, length and index
  always_ff @(posedge hz100) begin
    if (!reset) begin
      lfsr_r    <= SEED;
      start_q_r <= 1'b0;
      pb_q_r    <= '0;
      len_r     <= '0;
      idx_r     <= '0;
      for (int i = 0; i < MAX_LEN; i++) seq_r[i] <= '0;
    end else begin
      lfsr_r    <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      start_q_r <= start;
      pb_q_r    <= pb;
      if (len_clr_s)     len_r <= '0;
      else if (append_s) len_r <= len_r + LEN_ONE;
      else               len_r <= len_r;
      if (append_s) seq_r[len_r[IW-1:0]] <= elem_s;
      if (idx_clr_s)      idx_r <= '0;
      else if (idx_inc_s) idx_r <= idx_r + IDX_ONE;
      else                idx_r <= idx_r;
    end
  end

  // Tick divider; restarts on every state entry and on each accepted press
  always_ff @(posedge hz100) begin
    if (!reset) begin
      divcnt_r  <= '0;
      tickcnt_r <= '0;
    end else if ((state_next_s != state_r) || restart_s) begin
      divcnt_r  <= '0;
      tickcnt_r <= '0;
    end else if (tick_s) begin
      divcnt_r  <= '0;
      tickcnt_r <= tickcnt_r + TICK_ONE;
    end else begin
      divcnt_r  <= divcnt_r + DIV_ONE;
      tickcnt_r <= tickcnt_r;
    end
  end

  // Output decode from state registers; only the INPUT echo follows pb directly
  always_comb begin
    led   = '0;
    red   = 1'b0;
    green = 1'b0;
    blue  = 1'b0;
    state = state_r;
    level = len_r;
    case (state_r)
      S_SHOW_ON: led = expect_led_s;
      S_INPUT: begin
        led  = pb;
        blue = 1'b1;
      end
      S_WIN:   green = 1'b1;
      S_LOSE:  red   = 1'b1;
      default: led   = '0;
    endcase
  end

endmodule

// File: tb/tb_simon_says_multi.sv
// Randomised scoreboard bench for simon_says_multi: a timeline model predicts every output change
// (cycle, state, level, led) and a negedge monitor compares each observed change in order.
module tb_simon_says_multi;

  localparam int NB      = 4;
  localparam int ML      = 4;
  localparam int CL      = 1;
  localparam int ONT     = 2;
  localparam int TOT     = 3;
  localparam int EWB     = $clog2(NB);
  localparam int LWB     = $clog2(ML + 1);
  localparam int P       = CL + 1;
  localparam int ON_CYC  = ONT * P;
  localparam int OFF_CYC = P;
  localparam int TO_CYC  = TOT * P;
  localparam int ELEM_CYC = ON_CYC + OFF_CYC;
  localparam logic [7:0] SEED = 8'hA5;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_APPEND = 3'd1, ST_SHOW_ON = 3'd2,
                         ST_SHOW_OFF = 3'd3, ST_INPUT = 3'd4, ST_WIN = 3'd5, ST_LOSE = 3'd6;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [NB-1:0]  pb = '0;
  logic [NB-1:0]  led;
  logic [LWB-1:0] level;
  logic [2:0]     state;
  logic           red, green, blue;

  simon_says_multi #(
    .NUM_BTNS(NB), .MAX_LEN(ML), .CLKDIV_LIM(CL), .ON_TICKS(ONT),
    .TIMEOUT_TICKS(TOT), .SEED(SEED)
  ) dut (
    .hz100(clk), .reset(reset), .start(start), .pb(pb), .led(led),
    .level(level), .state(state), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // cycles since the last edge that sampled reset low
  int cyc = 0;
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int            cyc;
    logic [2:0]    st;
    int            lv;
    logic [NB-1:0] led;
  } ev_t;

  ev_t  exp_q[$];
  int   seq_m[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v;
    v = SEED;
    for (int k = 0; k < n; k++) v = {v[6:0], v[8-1] ^ v[6-1] ^ v[5-1] ^ v[4-1]};
    return v;
  endfunction

  function automatic int elem_at(input int n);
    int e;
    e = int'(lfsr_at(n)) % (1 << EWB);
    if (e >= NB) e = e - NB;
    return e;
  endfunction

  function automatic logic [NB-1:0] oh(input int e);
    logic [NB-1:0] v;
    v = '0;
    v[e] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic push_ev(input int t, input logic [2:0] st, input int lv, input logic [NB-1:0] ld);
    ev_t e;
    e.cyc = t;
    e.st  = st;
    e.lv  = lv;
    e.led = ld;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: every change of the visible outputs must match the next predicted event
  initial begin
    logic [3+LWB+NB+3-1:0] prev_t, cur_t, want_t;
    logic primed;
    ev_t e;
    primed = 1'b0;
    prev_t = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur_t = {state, level, led, red, green, blue};
        if (!primed) begin
          prev_t = cur_t;
          primed = 1'b1;
        end else if (cur_t != prev_t) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: cyc=%0d st=%0d lv=%0d led=%b rgb=%b%b%b, want no change",
                     cyc, state, level, led, red, green, blue);
          end else begin
            e = exp_q.pop_front();
            want_t = {e.st, LWB'(e.lv), e.led, e.st == ST_LOSE, e.st == ST_WIN, e.st == ST_INPUT};
            if (cur_t != want_t || cyc != e.cyc) begin
              errors++;
              $display("FAIL event: got cyc=%0d st=%0d lv=%0d led=%b rgb=%b%b%b, want cyc=%0d st=%0d lv=%0d led=%b rgb=%b%b%b",
                       cyc, state, level, led, red, green, blue,
                       e.cyc, e.st, e.lv, e.led, e.st == ST_LOSE, e.st == ST_WIN, e.st == ST_INPUT);
            end
          end
          prev_t = cur_t;
        end
      end
    end
  end

  // fail_kind: 0 win, 1 wrong button, 2 two buttons at once, 3 timeout; fails on last element of fail_round
  task automatic run_game(input int fail_kind, input int fail_round);
    int a, t_in, base, p, d;
    logic [NB-1:0] pv;
    logic [NB-1:0] two_btn;
    bit failing;
    two_btn = 4'b0011;
    repeat (3) step();
    a = cyc + 1;
    start = 1'b1;
    step();
    start = 1'b0;
    seq_m.delete();
    for (int r = 1; r <= ML; r++) begin
      seq_m.push_back(elem_at(a));
      push_ev(a, ST_APPEND, r - 1, '0);
      for (int k = 0; k < r; k++) begin
        push_ev(a + 1 + k * ELEM_CYC, ST_SHOW_ON, r, oh(seq_m[k]));
        push_ev(a + 1 + k * ELEM_CYC + ON_CYC, ST_SHOW_OFF, r, '0);
      end
      t_in = a + 1 + r * ELEM_CYC;
      push_ev(t_in, ST_INPUT, r, '0);
      if (r == 1) begin
        wait_until(a + 3);
        pb = 4'b0100;
        step();
        pb = '0;
      end
      if (r == 2) begin
        wait_until(a + 2);
        start = 1'b1;
        step();
        start = 1'b0;
      end
      wait_until(t_in);
      base = t_in;
      for (int i = 0; i < r; i++) begin
        failing = (fail_kind != 0) && (r == fail_round) && (i == r - 1);
        if (failing && fail_kind == 3) begin
          push_ev(base + TO_CYC, ST_LOSE, r, '0);
          wait_until(base + TO_CYC + 2);
          return;
        end
        d = (r == 2 && i == 0) ? TO_CYC - 1 : int'($urandom_range(TO_CYC - 1, 1));
        p = base + d;
        wait_until(p);
        if (failing && fail_kind == 1) pv = oh((seq_m[i] + 1 + int'($urandom_range(2, 0))) % NB);
        else if (failing)              pv = two_btn;
        else                           pv = oh(seq_m[i]);
        pb = pv;
        push_ev(p, ST_INPUT, r, pv);
        if (failing)         push_ev(p + 1, ST_LOSE, r, '0);
        else if (i < r - 1)  push_ev(p + 1, ST_INPUT, r, '0);
        else if (r == ML)    push_ev(p + 1, ST_WIN, r, '0);
        step();
        pb = '0;
        if (failing || (i == r - 1 && r == ML)) begin
          repeat (3) step();
          return;
        end
        base = p + 1;
      end
      a = cyc;
    end
  endtask

  task automatic reset_mid_show();
    int a;
    repeat (2) step();
    a = cyc + 1;
    start = 1'b1;
    push_ev(a, ST_APPEND, 0, '0);
    push_ev(a + 1, ST_SHOW_ON, 1, oh(elem_at(a)));
    step();
    start = 1'b0;
    wait_until(a + 2);
    reset = 1'b0;
    push_ev(0, ST_IDLE, 0, '0);
    step();
    reset = 1'b1;
    check("rst_mid_level", int'(level), 0);
    repeat (2) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_level", int'(level), 0);
    check("rst_led", int'(led), 0);
    check("rst_red", int'(red), 0);
    check("rst_green", int'(green), 0);
    check("rst_blue", int'(blue), 0);
    mon_en = 1'b1;
    run_game(0, 0);
    run_game(1, 2);
    run_game(2, 3);
    run_game(3, 1);
    run_game(3, 3);
    reset_mid_show();
    run_game(0, 0);
    repeat (4) step();
    check("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
